key_pio_irq: RTL and testbench



---
 rtl/key_pio_irq.sv | 141 ++++++++++++++
 tb/tb_key_pio_irq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_pio_irq.sv
// key_pio_irq: Avalon-MM input PIO for keys/switches with synchroniser,
// optional debouncer, edge capture and a maskable level interrupt.
// Optional feature macro: KEY_PIO_DEBOUNCE_EN (per-bit debounce counters).
// Register map: 0 DATA (ro), 1 reserved (reads 0), 2 IRQMASK (rw), 3 EDGECAP (read, W1C).
module key_pio_irq #(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   EDGE_TYPE       = 1,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] deb_q;
  logic [WIDTH-1:0] deb_d;
  logic [WIDTH-1:0] edgeCap_q;
  logic [WIDTH-1:0] edgeCap_d;
  logic [WIDTH-1:0] irqMask_q;
  logic [WIDTH-1:0] irqMask_d;
  logic [31:0]      readData_q;
  logic [31:0]      readData_d;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] clearBits;
  logic             wrEn;

  // Upper write data bits have no register behind them
  if (WIDTH < 32) begin : genUnusedWrite
    logic unusedHi;
    assign unusedHi = ^writedata[31:WIDTH];
  end

  // Two-flop synchroniser for the asynchronous key inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= IDLE_VEC;
      sync2_q <= IDLE_VEC;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

`ifdef KEY_PIO_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0][CW-1:0] cnt_q;
  logic [WIDTH-1:0][CW-1:0] cnt_d;

  // A bit must differ from the accepted level for DEBOUNCE_CYCLES edges in a row
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce counter state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam int unusedDebounceCycles = DEBOUNCE_CYCLES;

  assign deb_d = sync2_q;
`endif

  assign wrEn = chipselect & ~write_n;

  // Edge selection, mask write and write-1-to-clear; a new edge beats a clear
  always_comb begin
    edges = '0;
    case (EDGE_TYPE)
      0:       edges = ~deb_q & deb_d;
      1:       edges = deb_q & ~deb_d;
      default: edges = deb_q ^ deb_d;
    endcase
    clearBits = '0;
    if (wrEn && address == 2'd3) begin
      clearBits = writedata[WIDTH-1:0];
    end
    irqMask_d = irqMask_q;
    if (wrEn && address == 2'd2) begin
      irqMask_d = writedata[WIDTH-1:0];
    end
    edgeCap_d = (edgeCap_q & ~clearBits) | edges;
  end

  // Read mux; readdata is registered every clock regardless of chipselect
  always_comb begin
    readData_d = '0;
    case (address)
      2'd0:    readData_d[WIDTH-1:0] = deb_q;
      2'd2:    readData_d[WIDTH-1:0] = irqMask_q;
      2'd3:    readData_d[WIDTH-1:0] = edgeCap_q;
      default: readData_d = '0;
    endcase
  end

  // Accepted input state, capture/mask registers and read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q      <= IDLE_VEC;
      edgeCap_q  <= '0;
      irqMask_q  <= '0;
      readData_q <= '0;
    end else begin
      deb_q      <= deb_d;
      edgeCap_q  <= edgeCap_d;
      irqMask_q  <= irqMask_d;
      readData_q <= readData_d;
    end
  end

  assign readdata = readData_q;
  assign irq      = |(edgeCap_q & irqMask_q);

endmodule

// File: tb/tb_key_pio_irq.sv
// tb_key_pio_irq: directed scoreboard bench for key_pio_irq.
// Stimulus pushes expected read/irq values into queues; a monitor pops and
// compares them when the corresponding DUT output becomes valid.
module tb_key_pio_irq;

`ifdef KEY_PIO_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif
  localparam int DEBC = 4;
  // Edges from an in_port change (set between edges) until the accepted state updates
  localparam int LAT = DEB_EN ? (2 + DEBC) : 3;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } expT;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  logic rdReq   = 1'b0;
  logic rdValid = 1'b0;
  logic irqChk  = 1'b0;

  expT readQ[$];
  expT irqQ[$];
  int  checks = 0;
  int  errors = 0;

  key_pio_irq #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(DEBC),
    .EDGE_TYPE      (1),
    .IDLE_LEVEL     (1'b1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // readdata is valid one edge after a read request
  always @(posedge clk) rdValid <= rdReq;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance n edges, returning on a negedge with strobes cleared
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rdReq      = 1'b0;
      irqChk     = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] keys);
    in_port = keys;
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
  endtask

  task automatic checkRead(input logic [1:0] a, input logic [31:0] exp, input string name);
    expT e;
    e.name = name;
    e.exp  = exp;
    readQ.push_back(e);
    address = a;
    rdReq   = 1'b1;
  endtask

  task automatic checkIrq(input logic exp, input string name);
    expT e;
    e.name = name;
    e.exp  = {31'b0, exp};
    irqQ.push_back(e);
    irqChk = 1'b1;
  endtask

  // Monitor: compare against the scoreboard whenever an output is presented
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      #1;
      if (rdValid) begin
        if (readQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL readQueue: got read with empty scoreboard, expected an entry");
        end else begin
          e = readQ.pop_front();
          checkOutput(e.name, readdata, e.exp);
        end
      end
      if (irqChk) begin
        if (irqQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL irqQueue: got irq check with empty scoreboard, expected an entry");
        end else begin
          e = irqQ.pop_front();
          checkOutput(e.name, {31'b0, irq}, e.exp);
        end
      end
    end
  end

  // Watchdog bounding the whole run
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Directed stimulus
  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;
    tick(2);

    // Reset state
    checkIrq(1'b0, "irqReset");
    checkRead(2'd0, 32'h0, "rdReset");
    tick();
    reset_n = 1'b1;
    tick(3);
    checkRead(2'd0, 32'hF, "dataIdle");
    tick();
    checkRead(2'd3, 32'h0, "edgecapIdle");
    checkIrq(1'b0, "irqIdle");
    tick();

    // Masked bit1 falling edge raises irq exactly LAT edges later
    writeReg(2'd2, 32'h2);
    checkRead(2'd2, 32'h2, "maskRd");
    tick();
    applyStimulus(4'hD);
    tick(LAT - 1);
    checkIrq(1'b0, "irqBeforeEdge");
    tick();
    checkIrq(1'b1, "irqAfterEdge");
    checkRead(2'd3, 32'h2, "edgecapBit1");
    tick();
    checkRead(2'd0, 32'hD, "dataD");
    tick();

    // Short glitch on bit0 is rejected when debouncing
    applyStimulus(4'hC);
    tick(3);
    applyStimulus(4'hD);
    tick(10);
    checkRead(2'd0, 32'hD, "glitch3Data");
    tick();
    checkRead(2'd3, DEB_EN ? 32'h2 : 32'h3, "glitch3Cap");
    tick();

    // Pulse of exactly DEBOUNCE_CYCLES is accepted
    applyStimulus(4'hC);
    tick(4);
    applyStimulus(4'hD);
    tick(12);
    checkRead(2'd3, 32'h3, "glitch4Cap");
    tick();
    writeReg(2'd3, 32'h1);
    checkRead(2'd3, 32'h2, "capAfterW1C");
    tick();

    // Release keys, then clear bit1 on the very edge a new falling edge is accepted
    applyStimulus(4'hF);
    tick(LAT + 2);
    checkRead(2'd0, 32'hF, "releaseData");
    tick();
    applyStimulus(4'hD);
    tick(LAT - 1);
    writeReg(2'd3, 32'h2);
    checkIrq(1'b1, "irqSetWins");
    checkRead(2'd3, 32'h2, "capSetWins");
    tick();
    writeReg(2'd3, 32'h2);
    checkIrq(1'b0, "irqCleared");
    checkRead(2'd3, 32'h0, "capCleared");
    tick();

    // Capture bit3 while masked, then unmask
    writeReg(2'd2, 32'h0);
    applyStimulus(4'h5);
    tick(LAT + 1);
    checkIrq(1'b0, "irqMasked");
    checkRead(2'd3, 32'h8, "capMasked");
    tick();
    writeReg(2'd2, 32'h8);
    checkIrq(1'b1, "irqUnmasked");
    tick();

    // Reset in the middle of a debounce, then release with bit0 held pressed
    applyStimulus(4'hE);
    tick(3);
    reset_n = 1'b0;
    checkIrq(1'b0, "irqInReset");
    checkRead(2'd3, 32'h0, "capInReset");
    tick(2);
    reset_n = 1'b1;
    checkRead(2'd0, 32'hF, "dataRstRel");
    tick(LAT - 1);
    checkRead(2'd0, 32'hF, "dataPreAccept");
    tick();
    checkRead(2'd0, 32'hE, "dataAccepted");
    tick();
    checkRead(2'd3, 32'h1, "capAfterReset");
    checkIrq(1'b0, "irqMaskCleared");
    tick(4);

    checks++;
    if ((readQ.size() + irqQ.size()) != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending entries, expected 0", readQ.size() + irqQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
